// File: rtl/lbp_fetch_sched_if.sv
// ---------------------------------------------------------------------------
// lbp_fetch_sched_if
// Bundles the signals between the LBP fetch scheduler, the gray-image memory
// and the LBP window datapath.
//
//   gray_ready  image available (to scheduler)
//   hold        back-pressure from the datapath (to scheduler)
//   gray_req    read strobe, data returns one cycle later
//   gray_addr   {row,col} of the pixel being read
//   win_we      write returning gray data into window slot win_idx
//   win_idx     window slot 0..8 = 3*(dr+1)+(dc+1)
//   win_shift   00 none, 01 move right, 10 move left, 11 move down
//   lbp_valid   window complete for the centre at lbp_addr
//   lbp_addr    {row,col} of the current centre
//   finish      whole image processed, sticky until reset
//
// Flow control: there is no ready signal on the strobes. The datapath stalls
// the scheduler by raising hold. While hold is 1 (outside IDLE and DONE), the
// scheduler issues no gray_req, lbp_valid or win_shift, and its position
// does not advance. A read accepted by memory in the cycle before hold rises
// still returns, and its win_we is still presented.
// ---------------------------------------------------------------------------
interface lbp_fetch_sched_if #(
   parameter int AW = 7
);
   logic            gray_ready;
   logic            hold;
   logic            gray_req;
   logic [2*AW-1:0] gray_addr;
   logic            win_we;
   logic [3:0]      win_idx;
   logic [1:0]      win_shift;
   logic            lbp_valid;
   logic [2*AW-1:0] lbp_addr;
   logic            finish;

   modport master (
      input  gray_ready, hold,
      output gray_req, gray_addr, win_we, win_idx, win_shift,
             lbp_valid, lbp_addr, finish
   );

   modport slave (
      output gray_ready, hold,
      input  gray_req, gray_addr, win_we, win_idx, win_shift,
             lbp_valid, lbp_addr, finish
   );
endinterface

// File: rtl/lbp_fetch_sched.sv
// ---------------------------------------------------------------------------
// lbp_fetch_sched
// Walks the interior centres of a square gray image in snake order. Odd rows
// run left to right and even rows run right to left. For each centre the
// module fetches the 3x3 window. The first centre needs all 9 pixels. Each
// later centre needs only the 3 pixels that enter the window after a shift.
// The module drives the window slot writes and the shift pulses, and gives
// one lbp_valid strobe per centre. When the last centre is done it enters a
// sticky finish state.
//
// Ports
//   clk        clock
//   reset      asynchronous, active-high reset
//   bus        lbp_fetch_sched_if.master (memory and datapath signals)
//   fsm_state  current FSM state for debug:
//              0 IDLE, 1 FETCH, 2 WB, 3 CALC, 4 MOVE, 5 DONE
// ---------------------------------------------------------------------------
module lbp_fetch_sched #(
   parameter int AW = 7
) (
   input  logic                  clk,
   input  logic                  reset,
   lbp_fetch_sched_if.master     bus,
   output logic [2:0]            fsm_state
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_FETCH = 3'd1,
      S_WB    = 3'd2,
      S_CALC  = 3'd3,
      S_MOVE  = 3'd4,
      S_DONE  = 3'd5
   } state_t;

   // The fetch mode uses the same encoding as the win_shift code that caused
   // it. 00 has no shift, so it marks the initial full-window fetch.
   localparam logic [1:0] MODE_INIT  = 2'b00;
   localparam logic [1:0] MODE_RIGHT = 2'b01;
   localparam logic [1:0] MODE_LEFT  = 2'b10;
   localparam logic [1:0] MODE_DOWN  = 2'b11;

   localparam logic [AW-1:0] ONE  = {{(AW-1){1'b0}}, 1'b1};
   localparam logic [AW-1:0] LAST = {{(AW-1){1'b1}}, 1'b0};   // IMG_W-2

   state_t          state, state_nx;
   logic [AW-1:0]   row, col;          // current centre
   logic [1:0]      mode;              // which pixels the current FETCH reads
   logic [3:0]      cnt;               // read index within the FETCH
   logic            win_we_q;
   logic [3:0]      win_idx_q;

   logic [3:0]      last_cnt;
   logic            fetch_done;
   logic            last_centre;
   logic [1:0]      move_dir;
   logic [1:0]      r_sel, c_sel;      // 0..2 means dr/dc of -1..+1
   logic [3:0]      slot;
   logic [AW-1:0]   fetch_row, fetch_col;

   // ---------------------------------------------------------------------
   // Helper decode
   // ---------------------------------------------------------------------
   always_comb begin
      last_cnt    = (mode == MODE_INIT) ? 4'd8 : 4'd2;
      fetch_done  = (cnt == last_cnt);
      last_centre = (row == LAST) && (col == ONE);

      // At the end of a row, step down. Because the row parity then changes,
      // the next row runs in the opposite direction without extra state.
      if (row[0] && (col < LAST))
         move_dir = MODE_RIGHT;
      else if (!row[0] && (col > ONE))
         move_dir = MODE_LEFT;
      else
         move_dir = MODE_DOWN;
   end

   // Window offset of the pixel read at position cnt in the current FETCH.
   always_comb begin
      r_sel = 2'd0;
      c_sel = 2'd0;
      case (mode)
         MODE_INIT: begin
            if (cnt >= 4'd6) begin
               r_sel = 2'd2;
               c_sel = 2'(cnt - 4'd6);
            end else if (cnt >= 4'd3) begin
               r_sel = 2'd1;
               c_sel = 2'(cnt - 4'd3);
            end else begin
               r_sel = 2'd0;
               c_sel = cnt[1:0];
            end
         end
         MODE_RIGHT: begin
            r_sel = cnt[1:0];
            c_sel = 2'd2;
         end
         MODE_LEFT: begin
            r_sel = cnt[1:0];
            c_sel = 2'd0;
         end
         default: begin              // MODE_DOWN
            r_sel = 2'd2;
            c_sel = cnt[1:0];
         end
      endcase

      slot      = {1'b0, r_sel, 1'b0} + {2'b00, r_sel} + {2'b00, c_sel};
      // The centre is always interior, so centre-1 .. centre+1 never wraps.
      fetch_row = row - ONE + {{(AW-2){1'b0}}, r_sel};
      fetch_col = col - ONE + {{(AW-2){1'b0}}, c_sel};
   end

   // ---------------------------------------------------------------------
   // FSM: state register
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         state <= S_IDLE;
      else
         state <= state_nx;
   end

   // ---------------------------------------------------------------------
   // FSM: next-state logic. hold freezes only the active states.
   // ---------------------------------------------------------------------
   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE:  if (bus.gray_ready)          state_nx = S_FETCH;
         S_FETCH: if (!bus.hold && fetch_done) state_nx = S_WB;
         S_WB:    if (!bus.hold)               state_nx = S_CALC;
         S_CALC:  if (!bus.hold)               state_nx = last_centre ? S_DONE : S_MOVE;
         S_MOVE:  if (!bus.hold)               state_nx = S_FETCH;
         S_DONE:                               state_nx = S_DONE;
         default:                              state_nx = S_IDLE;
      endcase
   end

   // ---------------------------------------------------------------------
   // FSM: outputs
   // ---------------------------------------------------------------------
   always_comb begin
      bus.gray_req  = 1'b0;
      bus.gray_addr = '0;
      bus.lbp_valid = 1'b0;
      bus.lbp_addr  = '0;
      bus.win_shift = 2'b00;
      bus.finish    = 1'b0;
      case (state)
         S_FETCH: begin
            bus.gray_req  = !bus.hold;
            bus.gray_addr = {fetch_row, fetch_col};
         end
         S_CALC: begin
            bus.lbp_valid = !bus.hold;
            bus.lbp_addr  = {row, col};
         end
         S_MOVE: begin
            bus.win_shift = bus.hold ? 2'b00 : move_dir;
         end
         S_DONE: begin
            bus.finish = 1'b1;
         end
         default: ;
      endcase
      bus.win_we  = win_we_q;
      bus.win_idx = win_idx_q;
      fsm_state   = state;
   end

   // ---------------------------------------------------------------------
   // Centre position, fetch mode and read counter
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         row  <= ONE;
         col  <= ONE;
         mode <= MODE_INIT;
         cnt  <= 4'd0;
      end else begin
         case (state)
            S_IDLE: begin
               if (bus.gray_ready) begin
                  row  <= ONE;
                  col  <= ONE;
                  mode <= MODE_INIT;
                  cnt  <= 4'd0;
               end
            end
            S_FETCH: begin
               if (!bus.hold)
                  cnt <= fetch_done ? 4'd0 : cnt + 4'd1;
            end
            S_MOVE: begin
               if (!bus.hold) begin
                  mode <= move_dir;
                  cnt  <= 4'd0;
                  case (move_dir)
                     MODE_RIGHT: col <= col + ONE;
                     MODE_LEFT:  col <= col - ONE;
                     default:    row <= row + ONE;
                  endcase
               end
            end
            default: ;
         endcase
      end
   end

   // ---------------------------------------------------------------------
   // Window write: the read strobe and slot delayed one cycle to match the
   // memory latency. This path ignores hold, so an in-flight read lands.
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         win_we_q  <= 1'b0;
         win_idx_q <= 4'd0;
      end else begin
         win_we_q  <= bus.gray_req;
         win_idx_q <= bus.gray_req ? slot : 4'd0;
      end
   end

endmodule

// File: tb/tb_lbp_fetch_sched.sv
// ---------------------------------------------------------------------------
// tb_lbp_fetch_sched
// Directed bench for lbp_fetch_sched. A 128x128 instance covers addressing,
// the right/down/left moves, hold and reset mid-frame. A 16x16 instance runs
// a complete frame (196 centres) and checks the finish behaviour.
// Ports: none (top-level bench).
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_lbp_fetch_sched;

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_FETCH = 3'd1;
   localparam logic [2:0] ST_WB    = 3'd2;
   localparam logic [2:0] ST_MOVE  = 3'd4;

   // ---------------- clock / reset ----------------
   logic       clk = 1'b0;
   logic       reset;
   logic [2:0] bstate, sstate;

   always #5 clk = ~clk;

   lbp_fetch_sched_if #(.AW(7)) bif();
   lbp_fetch_sched_if #(.AW(4)) sif();

   lbp_fetch_sched #(.AW(7)) u_big (
      .clk       (clk),
      .reset     (reset),
      .bus       (bif.master),
      .fsm_state (bstate)
   );

   lbp_fetch_sched #(.AW(4)) u_small (
      .clk       (clk),
      .reset     (reset),
      .bus       (sif.master),
      .fsm_state (sstate)
   );

   // ---------------- scoreboard ----------------
   int          checks   = 0;
   int          failures = 0;
   int          cyc      = 0;
   int          big_cnt  = 0;
   logic [13:0] exp_q[$];
   logic [7:0]  sexp_q[$];
   logic [13:0] init_a[9] = '{14'd0, 14'd1, 14'd2, 14'd128, 14'd129, 14'd130,
                              14'd256, 14'd257, 14'd258};

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // Snake order of centres for the 128x128 image.
   task automatic fill_big();
      for (int r = 1; r <= 126; r++) begin
         for (int k = 1; k <= 126; k++) begin
            int c;
            c = (r % 2 == 1) ? k : 127 - k;
            exp_q.push_back(14'(r * 128 + c));
         end
      end
   endtask

   task automatic fill_small();
      for (int r = 1; r <= 14; r++) begin
         for (int k = 1; k <= 14; k++) begin
            int c;
            c = (r % 2 == 1) ? k : 15 - k;
            sexp_q.push_back(8'(r * 16 + c));
         end
      end
   endtask

   // ---------------- driver tasks ----------------
   // Advance one cycle. Sample 1ns after the edge and check every big-DUT
   // lbp_valid against the expected centre order.
   task automatic step();
      logic [13:0] e;
      @(posedge clk);
      #1;
      cyc++;
      if (bif.lbp_valid) begin
         big_cnt++;
         if (exp_q.size() != 0) e = exp_q.pop_front();
         else e = '1;
         check("lbp_order", 32'(bif.lbp_addr), 32'(e));
      end
   endtask

   task automatic wait_lbp(input string tag, input logic [13:0] addr, input int budget);
      bit found;
      found = 1'b0;
      for (int i = 0; i < budget && !found; i++) begin
         step();
         if (bif.lbp_valid && bif.lbp_addr == addr) found = 1'b1;
      end
      check(tag, 32'(found), 1);
   endtask

   // Called with the big DUT in MOVE. It checks the shift, the 3 reads, the
   // slot writes and the following CALC. It returns with the DUT in CALC.
   task automatic check_move(input string tag, input logic [1:0] shift,
                             input logic [13:0] a0, input logic [13:0] a1, input logic [13:0] a2,
                             input logic [3:0] s0, input logic [3:0] s1, input logic [3:0] s2,
                             input logic [13:0] centre);
      logic [13:0] a[3];
      logic [3:0]  s[3];
      a[0] = a0; a[1] = a1; a[2] = a2;
      s[0] = s0; s[1] = s1; s[2] = s2;
      check({tag, "_shift"}, 32'(bif.win_shift), 32'(shift));
      step();
      for (int i = 0; i < 3; i++) begin
         check({tag, "_req"}, 32'(bif.gray_req), 1);
         check({tag, "_addr"}, 32'(bif.gray_addr), 32'(a[i]));
         if (i > 0) begin
            check({tag, "_we"}, 32'(bif.win_we), 1);
            check({tag, "_idx"}, 32'(bif.win_idx), 32'(s[i-1]));
         end
         step();
      end
      check({tag, "_wb_we"}, 32'(bif.win_we), 1);
      check({tag, "_wb_idx"}, 32'(bif.win_idx), 32'(s[2]));
      step();
      check({tag, "_lbp_valid"}, 32'(bif.lbp_valid), 1);
      check({tag, "_lbp_addr"}, 32'(bif.lbp_addr), 32'(centre));
   endtask

   task automatic check_big_zero(input string tag);
      check({tag, "_req"},    32'(bif.gray_req), 0);
      check({tag, "_addr"},   32'(bif.gray_addr), 0);
      check({tag, "_we"},     32'(bif.win_we), 0);
      check({tag, "_idx"},    32'(bif.win_idx), 0);
      check({tag, "_shift"},  32'(bif.win_shift), 0);
      check({tag, "_valid"},  32'(bif.lbp_valid), 0);
      check({tag, "_laddr"},  32'(bif.lbp_addr), 0);
      check({tag, "_finish"}, 32'(bif.finish), 0);
      check({tag, "_state"},  32'(bstate), 32'(ST_IDLE));
   endtask

   // ---------------- watchdog ----------------
   initial begin
      #800000;
      $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
      $fatal(1, "watchdog expired");
   end

   // ---------------- main sequence ----------------
   initial begin
      int   s_cnt, s_last_cyc, fin_cyc;
      logic [7:0] s_last, se;
      bit   fin_seen, extra, fin_low;

      reset = 1'b1;
      bif.gray_ready = 1'b0; bif.hold = 1'b0;
      sif.gray_ready = 1'b0; sif.hold = 1'b0;
      repeat (3) step();
      check_big_zero("reset");
      reset = 1'b0;
      step();

      // ---- full frame on the 16x16 instance ----
      fill_small();
      s_cnt = 0; s_last = '0; s_last_cyc = 0; fin_cyc = 0; fin_seen = 1'b0;
      sif.gray_ready = 1'b1;
      step();
      sif.gray_ready = 1'b0;
      for (int i = 0; i < 3000 && !fin_seen; i++) begin
         if (sif.lbp_valid) begin
            s_cnt++;
            s_last = sif.lbp_addr;
            s_last_cyc = cyc;
            se = (sexp_q.size() != 0) ? sexp_q.pop_front() : 8'hff;
            check("small_lbp_order", 32'(sif.lbp_addr), 32'(se));
         end
         if (sif.finish) begin
            fin_seen = 1'b1;
            fin_cyc = cyc;
         end else begin
            step();
         end
      end
      check("small_finish_seen", 32'(fin_seen), 1);
      check("small_lbp_count", 32'(s_cnt), 196);
      check("small_last_addr", 32'(s_last), 225);
      check("small_finish_delay", 32'(fin_cyc - s_last_cyc), 1);

      // After DONE: gray_ready is ignored and finish stays high.
      extra = 1'b0; fin_low = 1'b0;
      sif.gray_ready = 1'b1;
      for (int i = 0; i < 20; i++) begin
         step();
         if (sif.gray_req || sif.lbp_valid || sif.win_we || (sif.win_shift != 2'b00)) extra = 1'b1;
         if (!sif.finish) fin_low = 1'b1;
      end
      sif.gray_ready = 1'b0;
      check("done_quiet", 32'(extra), 0);
      check("finish_sticky", 32'(fin_low), 0);

      // ---- 128x128: initial 9-pixel window ----
      fill_big();
      big_cnt = 0;
      bif.gray_ready = 1'b1;
      step();
      bif.gray_ready = 1'b0;
      for (int i = 0; i < 9; i++) begin
         check("init_req", 32'(bif.gray_req), 1);
         check("init_addr", 32'(bif.gray_addr), 32'(init_a[i]));
         if (i > 0) begin
            check("init_we", 32'(bif.win_we), 1);
            check("init_idx", 32'(bif.win_idx), 32'(i - 1));
         end
         step();
      end
      check("init_wb_req", 32'(bif.gray_req), 0);
      check("init_wb_we", 32'(bif.win_we), 1);
      check("init_wb_idx", 32'(bif.win_idx), 8);
      check("init_wb_state", 32'(bstate), 32'(ST_WB));
      step();
      check("init_lbp_valid", 32'(bif.lbp_valid), 1);
      check("init_lbp_addr", 32'(bif.lbp_addr), 129);
      step();
      check_move("right", 2'b01, 14'd3, 14'd131, 14'd259, 4'd2, 4'd5, 4'd8, 14'd130);

      // ---- end of row 1: down, then left ----
      wait_lbp("reach_1_126", 14'd254, 1000);
      step();
      check_move("down", 2'b11, 14'd509, 14'd510, 14'd511, 4'd6, 4'd7, 4'd8, 14'd382);
      step();
      check_move("left", 2'b10, 14'd252, 14'd380, 14'd508, 4'd0, 4'd3, 4'd6, 14'd381);

      // ---- hold for 5 cycles in the middle of FETCH of centre (2,124) ----
      step();
      check("hold_pre_shift", 32'(bif.win_shift), 2);
      step();
      check("hold_pre_addr0", 32'(bif.gray_addr), 251);
      step();
      check("hold_pre_addr1", 32'(bif.gray_addr), 379);
      bif.hold = 1'b1;
      #1;
      check("hold_req_off", 32'(bif.gray_req), 0);
      check("hold_inflight_we", 32'(bif.win_we), 1);
      check("hold_inflight_idx", 32'(bif.win_idx), 0);
      for (int k = 1; k <= 4; k++) begin
         step();
         check("hold_req", 32'(bif.gray_req), 0);
         check("hold_we", 32'(bif.win_we), 0);
         check("hold_state", 32'(bstate), 32'(ST_FETCH));
      end
      step();
      bif.hold = 1'b0;
      #1;
      check("hold_resume_req", 32'(bif.gray_req), 1);
      check("hold_resume_addr", 32'(bif.gray_addr), 379);
      step();
      check("hold_next_addr", 32'(bif.gray_addr), 507);
      check("hold_next_idx", 32'(bif.win_idx), 3);
      step();
      check("hold_wb_idx", 32'(bif.win_idx), 6);
      step();
      check("hold_lbp_valid", 32'(bif.lbp_valid), 1);
      check("hold_lbp_addr", 32'(bif.lbp_addr), 380);

      // ---- hold during MOVE suppresses the shift pulse ----
      step();
      bif.hold = 1'b1;
      #1;
      check("hold_move_shift", 32'(bif.win_shift), 0);
      step();
      check("hold_move_state", 32'(bstate), 32'(ST_MOVE));
      check("hold_move_shift2", 32'(bif.win_shift), 0);
      bif.hold = 1'b0;
      #1;
      check("hold_move_release", 32'(bif.win_shift), 2);
      step();
      check("hold_move_addr", 32'(bif.gray_addr), 250);

      // ---- reset during FETCH of centre (5,40) ----
      wait_lbp("reach_5_39", 14'd679, 5000);
      step();
      check("rst_pre_shift", 32'(bif.win_shift), 1);
      step();
      check("rst_pre_state", 32'(bstate), 32'(ST_FETCH));
      check("rst_pre_addr", 32'(bif.gray_addr), 553);
      step();
      check("rst_pending_we", 32'(bif.win_we), 1);
      reset = 1'b1;
      #1;
      check_big_zero("midrst");
      check("lbp_count_before_reset", 32'(big_cnt), 543);
      step();
      step();
      reset = 1'b0;
      exp_q.delete();
      fill_big();
      big_cnt = 0;
      step();
      check("restart_idle", 32'(bstate), 32'(ST_IDLE));
      bif.gray_ready = 1'b1;
      step();
      bif.gray_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         check("restart_addr", 32'(bif.gray_addr), 32'(init_a[i]));
         step();
      end
      wait_lbp("restart_first_lbp", 14'd129, 20);
      check("restart_lbp_count", 32'(big_cnt), 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
